// File: rtl/abs_diff_pkg.sv
// Shared types and arithmetic helpers for the approximate absolute-difference datapath.
// Helpers work on a fixed 33-bit container so any legal WIDTH (2..32) fits with a spare bit.
package abs_diff_pkg;

    localparam int MAX_W = 33;

    typedef enum logic [1:0] {
        MODE_EXACT     = 2'b00,
        MODE_RES_TRUNC = 2'b01,
        MODE_OPD_TRUNC = 2'b10,
        MODE_RSVD      = 2'b11
    } mode_e;

    function automatic logic [MAX_W-1:0] clear_low_f(input logic [MAX_W-1:0] v, input int n);
        logic [MAX_W-1:0] mask;
        mask = {MAX_W{1'b1}} << n;
        return v & mask;
    endfunction

    function automatic logic [MAX_W-1:0] abs_diff_f(input logic [MAX_W-1:0] x, input logic [MAX_W-1:0] y);
        return (x >= y) ? (x - y) : (y - x);
    endfunction

endpackage

// File: rtl/abs_diff_core.sv
// Combinational exact/approximate absolute difference and the error between them.
module abs_diff_core
    import abs_diff_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int APPROX_LSB = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] exact,
    output logic [WIDTH-1:0] approx,
    output logic [WIDTH-1:0] err
);

    logic [WIDTH-1:0] exact_s;
    logic [WIDTH-1:0] opd_s;
    logic [WIDTH-1:0] approx_s;
    logic [WIDTH-1:0] err_s;

    // Every difference of two WIDTH-bit values fits back into WIDTH bits, so the casts are lossless
    always_comb begin
        exact_s = WIDTH'(abs_diff_f(MAX_W'(a), MAX_W'(b)));
        opd_s   = WIDTH'(abs_diff_f(clear_low_f(MAX_W'(a), APPROX_LSB),
                                    clear_low_f(MAX_W'(b), APPROX_LSB)));
        case (mode_e'(mode))
            MODE_RES_TRUNC: approx_s = WIDTH'(clear_low_f(MAX_W'(exact_s), APPROX_LSB));
            MODE_OPD_TRUNC: approx_s = opd_s;
            default:        approx_s = exact_s;
        endcase
        err_s = WIDTH'(abs_diff_f(MAX_W'(exact_s), MAX_W'(approx_s)));
    end

    assign exact  = exact_s;
    assign approx = approx_s;
    assign err    = err_s;

endmodule

// File: rtl/abs_diff_approx_pipe.sv
// Two-stage streaming approximate |a-b| with per-sample error check and running statistics.
module abs_diff_approx_pipe
    import abs_diff_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int APPROX_LSB = 1,
    parameter int COUNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    input  logic [1:0]         mode_i,
    input  logic [WIDTH-1:0]   et_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   diff_o,
    output logic [WIDTH-1:0]   err_o,
    output logic               viol_o,
    input  logic               clr_stats_i,
    output logic [COUNT_W-1:0] sample_cnt_o,
    output logic [COUNT_W-1:0] viol_cnt_o,
    output logic [WIDTH-1:0]   max_err_o
);

    logic               s1_valid_r;
    logic [WIDTH-1:0]   s1_a_r;
    logic [WIDTH-1:0]   s1_b_r;
    logic [1:0]         s1_mode_r;
    logic [WIDTH-1:0]   s1_et_r;

    logic               out_valid_r;
    logic [WIDTH-1:0]   diff_r;
    logic [WIDTH-1:0]   err_r;
    logic               viol_r;

    logic [COUNT_W-1:0] sample_cnt_r;
    logic [COUNT_W-1:0] viol_cnt_r;
    logic [WIDTH-1:0]   max_err_r;

    logic               s2_load_s;
    logic               s1_load_s;
    logic               in_ready_s;
    logic               xfer_s;
    logic [WIDTH-1:0]   exact_s;
    logic [WIDTH-1:0]   approx_s;
    logic [WIDTH-1:0]   core_err_s;
    logic               exact_unused_s;

    // Pipeline advance: S1 may refill in the same cycle it hands its beat to S2
    always_comb begin
        s2_load_s  = s1_valid_r & (~out_valid_r | out_ready);
        in_ready_s = rst_n & (~s1_valid_r | s2_load_s);
        s1_load_s  = in_valid & in_ready_s;
        xfer_s     = out_valid_r & out_ready;
    end

    abs_diff_core #(
        .WIDTH      (WIDTH),
        .APPROX_LSB (APPROX_LSB)
    ) u_core (
        .a      (s1_a_r),
        .b      (s1_b_r),
        .mode   (s1_mode_r),
        .exact  (exact_s),
        .approx (approx_s),
        .err    (core_err_s)
    );

    // The exact value is only needed inside the core to derive the error
    assign exact_unused_s = ^exact_s;

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= '0;
            s1_b_r     <= '0;
            s1_mode_r  <= 2'b00;
            s1_et_r    <= '0;
        end else if (s1_load_s) begin
            s1_valid_r <= 1'b1;
            s1_a_r     <= a_i;
            s1_b_r     <= b_i;
            s1_mode_r  <= mode_i;
            s1_et_r    <= et_i;
        end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
        end
    end

    // Stage 2: result registers, held while the consumer stalls
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            diff_r      <= '0;
            err_r       <= '0;
            viol_r      <= 1'b0;
        end else if (s2_load_s) begin
            out_valid_r <= 1'b1;
            diff_r      <= approx_s;
            err_r       <= core_err_s;
            viol_r      <= (core_err_s > s1_et_r);
        end else if (xfer_s) begin
            out_valid_r <= 1'b0;
        end
    end

    // Statistics count only delivered results; a clear drops a coincident transfer
    always_ff @(posedge clk) begin
        if (!rst_n || clr_stats_i) begin
            sample_cnt_r <= '0;
            viol_cnt_r   <= '0;
            max_err_r    <= '0;
        end else if (xfer_s) begin
            if (sample_cnt_r != {COUNT_W{1'b1}}) begin
                sample_cnt_r <= sample_cnt_r + COUNT_W'(1);
            end
            if (viol_r && (viol_cnt_r != {COUNT_W{1'b1}})) begin
                viol_cnt_r <= viol_cnt_r + COUNT_W'(1);
            end
            if (err_r > max_err_r) begin
                max_err_r <= err_r;
            end
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign diff_o       = diff_r;
    assign err_o        = err_r;
    assign viol_o       = viol_r;
    assign sample_cnt_o = sample_cnt_r;
    assign viol_cnt_o   = viol_cnt_r;
    assign max_err_o    = max_err_r;

endmodule

// File: tb/tb_abs_diff_approx_pipe.sv
// Randomized and directed bench for abs_diff_approx_pipe against an arithmetic reference model.
module tb_abs_diff_approx_pipe;

    localparam int W = 4;
    localparam int L = 1;

    typedef struct packed {
        logic [W-1:0] diff;
        logic [W-1:0] err;
        logic         viol;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b0;
    logic clr_stats_i = 1'b0;
    logic [W-1:0] a_i = '0, b_i = '0, et_i = '0;
    logic [1:0] mode_i = 2'b00;

    logic in_ready, out_valid, viol_o;
    logic [W-1:0] diff_o, err_o, max_err_o;
    logic [15:0] sample_cnt_o, viol_cnt_o;

    logic in_ready3, out_valid3, viol3;
    logic [W-1:0] diff3, err3, max_err3;
    logic [2:0] sample_cnt3, viol_cnt3;

    int n_cmp = 0;
    int n_bad = 0;
    res_t exp_q[$];
    int m_cnt, m_vcnt, m_cnt3, m_vcnt3, m_max;

    always #5 clk = ~clk;

    abs_diff_approx_pipe #(.WIDTH(W), .APPROX_LSB(L), .COUNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a_i(a_i), .b_i(b_i), .mode_i(mode_i), .et_i(et_i),
        .out_valid(out_valid), .out_ready(out_ready),
        .diff_o(diff_o), .err_o(err_o), .viol_o(viol_o), .clr_stats_i(clr_stats_i),
        .sample_cnt_o(sample_cnt_o), .viol_cnt_o(viol_cnt_o), .max_err_o(max_err_o)
    );

    abs_diff_approx_pipe #(.WIDTH(W), .APPROX_LSB(L), .COUNT_W(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready3),
        .a_i(a_i), .b_i(b_i), .mode_i(mode_i), .et_i(et_i),
        .out_valid(out_valid3), .out_ready(out_ready),
        .diff_o(diff3), .err_o(err3), .viol_o(viol3), .clr_stats_i(clr_stats_i),
        .sample_cnt_o(sample_cnt3), .viol_cnt_o(viol_cnt3), .max_err_o(max_err3)
    );

    // Reference: plain integer arithmetic from the mode definitions
    function automatic res_t ref_model(int a, int b, int mode, int et);
        int q, ex, ap, aa, bb, er;
        res_t r;
        q  = 1 << L;
        ex = (a > b) ? a - b : b - a;
        case (mode)
            1:       ap = (ex / q) * q;
            2:       begin aa = (a / q) * q; bb = (b / q) * q; ap = (aa > bb) ? aa - bb : bb - aa; end
            default: ap = ex;
        endcase
        er = (ex > ap) ? ex - ap : ap - ex;
        r.diff = W'(ap);
        r.err  = W'(er);
        r.viol = (er > et);
        return r;
    endfunction

    function automatic void clear_model_stats();
        m_cnt = 0; m_vcnt = 0; m_cnt3 = 0; m_vcnt3 = 0; m_max = 0;
    endfunction

    // One clock: sample handshakes mid-cycle, update the model, return at posedge+1
    task automatic clk_cycle(output logic got, output res_t e, output res_t o, output logic acc);
        @(negedge clk);
        got = 1'b0; acc = 1'b0; e = '0; o = '0;
        if (!rst_n) begin
            exp_q.delete();
            clear_model_stats();
        end else begin
            if (out_valid === 1'b1 && out_ready) begin
                got = 1'b1;
                o = '{diff_o, err_o, viol_o};
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    if (!clr_stats_i) begin
                        m_cnt  = (m_cnt  < 65535) ? m_cnt + 1 : m_cnt;
                        m_cnt3 = (m_cnt3 < 7)     ? m_cnt3 + 1 : m_cnt3;
                        if (e.viol) begin
                            m_vcnt  = (m_vcnt  < 65535) ? m_vcnt + 1 : m_vcnt;
                            m_vcnt3 = (m_vcnt3 < 7)     ? m_vcnt3 + 1 : m_vcnt3;
                        end
                        if (int'(e.err) > m_max) m_max = int'(e.err);
                    end
                end else begin
                    e = 'x;
                end
            end
            if (clr_stats_i) clear_model_stats();
            if (in_valid && in_ready === 1'b1) begin
                acc = 1'b1;
                exp_q.push_back(ref_model(a_i, b_i, mode_i, et_i));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic got, acc;
        res_t e, o;
        rst_n = 1'b0; in_valid = 1'b1; a_i = W'($urandom); b_i = W'($urandom);
        for (int i = 0; i < 3; i++) begin
            clk_cycle(got, e, o, acc);
            n_cmp++;
            if ({in_ready, out_valid, sample_cnt_o, viol_cnt_o, max_err_o, in_ready3, out_valid3, sample_cnt3} !== '0) begin
                n_bad++;
                $display("FAIL reset_state: in_ready=%b out_valid=%b cnt=%0d vcnt=%0d max=%0d, required all 0",
                         in_ready, out_valid, sample_cnt_o, viol_cnt_o, max_err_o);
            end
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
        end
        for (int i = 0; i < 3; i++) begin
            clk_cycle(got, e, o, acc);
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_spurious: out_valid=%b required 0", out_valid);
            end
        end
    endtask

    task automatic test_directed(string name, int a, int b, int mode, int et, int ed, int ee, int ev);
        logic got, acc;
        res_t e, o, want;
        want = '{W'(ed), W'(ee), ev[0]};
        out_ready = 1'b1; in_valid = 1'b1;
        a_i = W'(a); b_i = W'(b); mode_i = 2'(mode); et_i = W'(et);
        clk_cycle(got, e, o, acc);
        in_valid = 1'b0;
        n_cmp++;
        if (acc !== 1'b1 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL %s_accept: accepted=%b out_valid=%b required 1/0", name, acc, out_valid);
        end
        clk_cycle(got, e, o, acc);
        n_cmp++;
        if (out_valid !== 1'b1 || {diff_o, err_o, viol_o} !== want) begin
            n_bad++;
            $display("FAIL %s_result: valid=%b diff=%0d err=%0d viol=%b required 1 %0d %0d %0d",
                     name, out_valid, diff_o, err_o, viol_o, ed, ee, ev);
        end
        clk_cycle(got, e, o, acc);
        n_cmp++;
        if (!got || o !== e) begin
            n_bad++;
            $display("FAIL %s_model: got=%b observed=%h model=%h", name, got, o, e);
        end
        n_cmp++;
        if (sample_cnt_o !== 16'(m_cnt) || viol_cnt_o !== 16'(m_vcnt) || max_err_o !== W'(m_max)) begin
            n_bad++;
            $display("FAIL %s_stats: cnt=%0d vcnt=%0d max=%0d required %0d %0d %0d",
                     name, sample_cnt_o, viol_cnt_o, max_err_o, m_cnt, m_vcnt, m_max);
        end
    endtask

    task automatic test_backpressure();
        logic got, acc;
        res_t e, o, held;
        int sent = 0, delivered = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 30 && delivered < 4; c++) begin
            in_valid = (sent < 4);
            a_i = W'($urandom); b_i = W'($urandom); mode_i = 2'($urandom); et_i = W'($urandom);
            if (c == 4) out_ready = 1'b1;
            clk_cycle(got, e, o, acc);
            if (acc) sent++;
            if (got) begin
                delivered++;
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL bp_order beat%0d: observed=%h model=%h", delivered, o, e);
                end
            end
            if (c == 1) held = '{diff_o, err_o, viol_o};
            if (c == 2 || c == 3) begin
                n_cmp++;
                if (in_ready !== 1'b0 || sent != 2 || out_valid !== 1'b1 || {diff_o, err_o, viol_o} !== held) begin
                    n_bad++;
                    $display("FAIL bp_stall c%0d: in_ready=%b accepted=%0d out=%h required 0 2 %h",
                             c, in_ready, sent, {diff_o, err_o, viol_o}, held);
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (delivered != 4 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_delivered: delivered=%0d left=%0d required 4 0", delivered, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic got, acc;
        res_t e, o;
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 3) != 0);
            clr_stats_i = ($urandom_range(0, 49) == 0);
            a_i = W'($urandom); b_i = W'($urandom); mode_i = 2'($urandom);
            et_i = ($urandom_range(0, 3) == 0) ? {W{1'b1}} : W'($urandom_range(0, 2));
            clk_cycle(got, e, o, acc);
            if (got) begin
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL rand_data c%0d: observed=%h model=%h", c, o, e);
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1; clr_stats_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            clk_cycle(got, e, o, acc);
            if (got) begin
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL rand_drain: observed=%h model=%h", o, e);
                end
            end
        end
        n_cmp++;
        if (exp_q.size() != 0 || sample_cnt_o !== 16'(m_cnt) || viol_cnt_o !== 16'(m_vcnt) || max_err_o !== W'(m_max)
            || sample_cnt3 !== 3'(m_cnt3) || viol_cnt3 !== 3'(m_vcnt3)) begin
            n_bad++;
            $display("FAIL rand_stats: left=%0d cnt=%0d vcnt=%0d max=%0d cnt3=%0d required 0 %0d %0d %0d %0d",
                     exp_q.size(), sample_cnt_o, viol_cnt_o, max_err_o, sample_cnt3, m_cnt, m_vcnt, m_max, m_cnt3);
        end
    endtask

    task automatic test_saturate_clear();
        logic got, acc;
        res_t e, o;
        int sent = 0;
        out_ready = 1'b1; in_valid = 1'b0; clr_stats_i = 1'b1;
        clk_cycle(got, e, o, acc);
        clr_stats_i = 1'b0;
        for (int c = 0; c < 40 && (sent < 9 || exp_q.size() != 0); c++) begin
            in_valid = (sent < 9);
            a_i = W'($urandom); b_i = W'($urandom); mode_i = 2'($urandom); et_i = W'($urandom);
            clk_cycle(got, e, o, acc);
            if (acc) sent++;
            if (got) begin
                n_cmp++;
                if (o !== e) begin
                    n_bad++;
                    $display("FAIL sat_data: observed=%h model=%h", o, e);
                end
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (sample_cnt3 !== 3'd7 || sample_cnt_o !== 16'd9 || viol_cnt3 !== 3'(m_vcnt3)) begin
            n_bad++;
            $display("FAIL sat_count: cnt3=%0d cnt=%0d vcnt3=%0d required 7 9 %0d", sample_cnt3, sample_cnt_o, viol_cnt3, m_vcnt3);
        end
        in_valid = 1'b1; a_i = 4'd12; b_i = 4'd1; mode_i = 2'b01; et_i = 4'd0;
        clk_cycle(got, e, o, acc);
        in_valid = 1'b0;
        for (int c = 0; c < 5 && out_valid !== 1'b1; c++) clk_cycle(got, e, o, acc);
        clr_stats_i = 1'b1;
        clk_cycle(got, e, o, acc);
        clr_stats_i = 1'b0;
        n_cmp++;
        if (!got || o !== e) begin
            n_bad++;
            $display("FAIL clr_xfer_data: got=%b observed=%h model=%h", got, o, e);
        end
        clk_cycle(got, e, o, acc);
        n_cmp++;
        if ({sample_cnt_o, viol_cnt_o, max_err_o, sample_cnt3, viol_cnt3, max_err3} !== '0) begin
            n_bad++;
            $display("FAIL clr_stats: cnt=%0d vcnt=%0d max=%0d cnt3=%0d required all 0",
                     sample_cnt_o, viol_cnt_o, max_err_o, sample_cnt3);
        end
    endtask

    initial begin
        clear_model_stats();
        test_reset();
        test_directed("exact",        9, 3, 0, 0,  6, 0, 0);
        test_directed("res_trunc",    2, 9, 1, 0,  6, 1, 1);
        test_directed("opd_trunc",    7, 2, 2, 1,  4, 1, 0);
        test_directed("et_all_ones",  2, 9, 1, 15, 6, 1, 0);
        test_directed("reserved",     3, 14, 3, 0, 11, 0, 0);
        test_backpressure();
        test_random();
        test_saturate_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
